// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// Pure declarations; no logic, no latency.
package pipe_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_hazard_unit.sv
// Load-use hazard detect: EX load whose destination feeds the ID instruction.
// Purely combinational (zero latency); it has no handshake of its own.
module pipe_hazard_unit
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_RegisterRd,
  output logic                  load_use_stall
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use_stall = ex_MemRead && (ex_RegisterRd != '0) &&
                          ((ex_RegisterRd == id_rs) ||
                           (id_uses_rt && (ex_RegisterRd == id_rt)));
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: strobes are combinational from state + inputs (zero latency).
// Priority: memory wait > taken branch > load-use > normal; HALT freezes everything.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_RegisterRd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  wb_call,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  halted,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                load_use_stall;
  logic                mem_stall;

  pipe_hazard_unit u_hazard (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_MemRead     (ex_MemRead),
    .ex_RegisterRd  (ex_RegisterRd),
    .load_use_stall (load_use_stall)
  );

  assign mem_stall = mem_req && !mem_ack;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;

    if (state_q == ST_HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      if (resume) state_d = ST_RUN;
    end else if (mem_stall) begin
      // Upstream frozen; the access stays in EX/MEM while WB receives bubbles.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
        wait_d  = '0;
      end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
        state_d   = ST_HALT;
        timeout_d = 1'b1;
        wait_d    = '0;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_stall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      state_d = (state_q == ST_RUN && wb_call) ? ST_HALT : ST_RUN;
      wait_d  = '0;
    end

    if (!rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && state_q != ST_HALT && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench: driver pushes model expectations, monitor pops and compares.
// Two DUTs share stimulus; the 2-bit counter copy exercises saturation.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_RegisterRd = '0;
  logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ack = 1'b0, wb_call = 1'b0, resume = 1'b0;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_halt, a_to;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_halt, b_to;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegisterRd(ex_RegisterRd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .wb_call(wb_call), .resume(resume),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
    .ifid_flush(a_fifid), .idex_flush(a_fidex), .exmem_flush(a_fexmem), .memwb_flush(a_fmemwb),
    .halted(a_halt), .mem_timeout(a_to), .stall_cnt(a_cnt)
  );

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RegisterRd(ex_RegisterRd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .wb_call(wb_call), .resume(resume),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
    .ifid_flush(b_fifid), .idex_flush(b_fidex), .exmem_flush(b_fexmem), .memwb_flush(b_fmemwb),
    .halted(b_halt), .mem_timeout(b_to), .stall_cnt(b_cnt)
  );

  typedef struct {
    int         cyc;
    logic [10:0] strobes;  // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush, halted, timeout}
    int         stalls;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: abstract pipeline condition, not the RTL state encoding.
  bit m_halted, m_waiting, m_timeout;
  int m_waited, m_stalls;

  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit mr, input logic [4:0] rd, input bit br, input bit mreq,
                      input bit mack, input bit call, input bit res);
    exp_t     e;
    bit       ms, lu;
    bit [4:0] en;
    bit [3:0] fl;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_MemRead = mr; ex_RegisterRd = rd;
    ex_branch_taken = br; mem_req = mreq; mem_ack = mack; wb_call = call; resume = res;
    cyc++;
    e.cyc = cyc;
    if (!r) begin
      m_halted = 0; m_waiting = 0; m_timeout = 0; m_waited = 0; m_stalls = 0;
      e.strobes = {5'b00000, 4'b1111, 1'b0, 1'b0};
      e.stalls  = 0;
    end else begin
      ms = mreq && !mack;
      lu = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
      en = 5'b11111;
      fl = 4'b0000;
      if (m_halted)   en = 5'b00000;
      else if (ms)    begin en = 5'b00001; fl = 4'b0001; end
      else if (br)    fl = 4'b1100;
      else if (lu)    begin en = 5'b00111; fl = 4'b0100; end
      e.strobes = {en, fl, m_halted, m_timeout};
      e.stalls  = m_stalls;
      if (!m_halted && !en[4]) m_stalls++;
      if (m_halted) begin
        if (res) m_halted = 0;
      end else if (ms) begin
        if (!m_waiting) begin
          m_waiting = 1; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited >= TO) begin m_timeout = 1; m_halted = 1; m_waiting = 0; end
        end
      end else begin
        if (!m_waiting && call) m_halted = 1;
        m_waiting = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle presents a strobe set; compare against the oldest expectation.
  initial begin
    exp_t e;
    int   sat;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        sat = (e.stalls > 3) ? 3 : e.stalls;
        checks++;
        if ({a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_halt, a_to} !== e.strobes) begin
          errors++;
          $display("FAIL strobes cyc %0d: got %b want %b", e.cyc,
                   {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_halt, a_to}, e.strobes);
        end
        checks++;
        if (a_cnt !== 16'(e.stalls)) begin
          errors++;
          $display("FAIL stall_cnt cyc %0d: got %0d want %0d", e.cyc, a_cnt, e.stalls);
        end
        checks++;
        if ({b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_halt, b_to} !== e.strobes) begin
          errors++;
          $display("FAIL sat_strobes cyc %0d: got %b want %b", e.cyc,
                   {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_halt, b_to}, e.strobes);
        end
        checks++;
        if (b_cnt !== 2'(sat)) begin
          errors++;
          $display("FAIL sat_cnt cyc %0d: got %0d want %0d", e.cyc, b_cnt, sat);
        end
      end
    end
  end

  initial begin
    bit pend;
    bit mreq, mack, r;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // load-use on rs, then bubble in EX
    step(1, 8, 3, 1, 1, 8, 0, 0, 0, 0, 0);
    step(1, 8, 3, 1, 0, 8, 0, 0, 0, 0, 0);
    // rt match but rt unused; rd = 0
    step(1, 2, 8, 0, 1, 8, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 5, 8, 1, 1, 8, 0, 0, 0, 0, 0);
    // branch + load-use together
    step(1, 8, 8, 1, 1, 8, 1, 0, 0, 0, 0);
    idle();
    // memory wait, ack on 4th cycle
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle();
    // memory timeout, then resume
    repeat (7) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(); idle();
    // wb call halt, then resume
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // reset mid-wait and mid-halt
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // randomized traffic; a memory request is held until acknowledged
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 99) >= 2);
      mreq = pend || ($urandom_range(0, 3) == 0);
      mack = mreq && ($urandom_range(0, 2) == 0);
      pend = r && mreq && !mack;
      step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2),
           mreq, mack, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0));
    end
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
